// File: rtl/rx_cmd_ctrl.sv
// Command controller between a UART receiver, a register file, an ALU and a TX FIFO.
// Decodes byte-oriented commands, sequences RF/ALU accesses and returns results as TX bytes.
module rx_cmd_ctrl #(
  parameter int ADDR_W = 4,
  parameter int TO_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              RX_ERR,
  output logic              RF_WrEn,
  output logic              RF_RdEn,
  output logic [ADDR_W-1:0] RF_Address,
  output logic [7:0]        RF_WrData,
  input  logic [7:0]        RF_RdData,
  input  logic              RF_RdData_VLD,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  input  logic [15:0]       ALU_OUT,
  input  logic              ALU_OUT_VLD,
  output logic              CLK_GATE_EN,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_FULL,
  output logic              CMD_ERR
);
  localparam int               CNT_W   = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FN, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        rd_buf_q, rd_buf_d;
  logic [15:0]       alu_res_q, alu_res_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [3:0]        alu_fun_q, alu_fun_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
  logic              gate_q, gate_d, tx_vld_q, tx_vld_d, cmd_err_q, cmd_err_d;
  logic              acc, timed, busy, to_hit;

  always_comb begin
    acc    = RX_D_VLD && !RX_ERR;
    timed  = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN};
    busy   = state_q inside {RD_WAIT, ALU_WAIT, SEND_RD, SEND_LO, SEND_HI};
    // an accepted byte in the expiry cycle wins over the timeout
    to_hit = timed && !acc && (to_cnt_q == TO_LAST);

    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_buf_d  = rd_buf_q;
    alu_res_d = alu_res_q;
    rf_addr_d = rf_addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = busy && acc;
    to_cnt_d  = (timed && !acc) ? to_cnt_q + CNT_W'(1) : '0;

    case (state_q)
      IDLE: if (acc) begin
        case (RX_P_DATA)
          8'hAA:   state_d = WR_ADDR;
          8'hBB:   state_d = RD_ADDR;
          8'hCC:   state_d = OP_A;
          8'hDD:   state_d = ALU_FN;
          default: cmd_err_d = 1'b1;
        endcase
      end
      WR_ADDR: if (acc) begin
        wr_addr_d = ADDR_W'(RX_P_DATA);
        state_d   = WR_DATA;
      end
      WR_DATA: if (acc) begin
        wr_en_d   = 1'b1;
        rf_addr_d = wr_addr_q;
        wr_data_d = RX_P_DATA;
        state_d   = IDLE;
      end
      RD_ADDR: if (acc) begin
        rd_en_d   = 1'b1;
        rf_addr_d = ADDR_W'(RX_P_DATA);
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (RF_RdData_VLD) begin
        rd_buf_d = RF_RdData;
        state_d  = SEND_RD;
      end
      OP_A: if (acc) begin
        wr_en_d   = 1'b1;
        rf_addr_d = ADDR_W'(0);
        wr_data_d = RX_P_DATA;
        state_d   = OP_B;
      end
      OP_B: if (acc) begin
        wr_en_d   = 1'b1;
        rf_addr_d = ADDR_W'(1);
        wr_data_d = RX_P_DATA;
        state_d   = ALU_FN;
      end
      ALU_FN: if (acc) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        alu_res_d = ALU_OUT;
        state_d   = SEND_LO;
      end
      SEND_RD: if (!TX_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rd_buf_q;
        state_d   = IDLE;
      end
      SEND_LO: if (!TX_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = alu_res_q[7:0];
        state_d   = SEND_HI;
      end
      SEND_HI: if (!TX_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = alu_res_q[15:8];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (to_hit) begin
      state_d   = IDLE;
      cmd_err_d = 1'b1;
      to_cnt_d  = '0;
    end
    // gate stays open from the ALU_EN cycle through the result capture cycle
    gate_d = (state_d == ALU_WAIT);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      wr_addr_q <= '0;
      rd_buf_q  <= '0;
      alu_res_q <= '0;
      rf_addr_q <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      gate_q    <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_buf_q  <= rd_buf_d;
      alu_res_q <= alu_res_d;
      rf_addr_q <= rf_addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      gate_q    <= gate_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign RF_WrEn     = wr_en_q;
  assign RF_RdEn     = rd_en_q;
  assign RF_Address  = rf_addr_q;
  assign RF_WrData   = wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Scoreboard bench for rx_cmd_ctrl: command-level reference model feeds expectation queues,
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_rx_cmd_ctrl;
  localparam int         ADDR_W = 4;
  localparam int         TO_CYC = 16;
  localparam logic [7:0] AMASK  = 8'((1 << ADDR_W) - 1);

  logic              CLK = 1'b0, RST = 1'b0;
  logic [7:0]        RX_P_DATA = 8'h00;
  logic              RX_D_VLD = 1'b0, RX_ERR = 1'b0;
  logic              RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR;
  logic [ADDR_W-1:0] RF_Address;
  logic [7:0]        RF_WrData, TX_P_DATA;
  logic [3:0]        ALU_FUN;
  logic [7:0]        RF_RdData = 8'h00;
  logic              RF_RdData_VLD = 1'b0;
  logic [15:0]       ALU_OUT = 16'h0000;
  logic              ALU_OUT_VLD = 1'b0;
  logic              TX_FULL = 1'b0;

  rx_cmd_ctrl #(.ADDR_W(ADDR_W), .TO_CYC(TO_CYC)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_FULL(TX_FULL), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc_n = 0;
  always @(posedge CLK) cyc_n++;

  int          total = 0, bad = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];
  int          err_pend = 0;
  logic [7:0]  ref_mem[256];
  logic [7:0]  rf[256];
  int          rdvld_cyc = 0, tx_cyc = 0;
  int          stall_n = 0;
  bit          noise = 1'b0;
  bit          in_alu = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {8'h00, a & b};
      default: return {a ^ {4'h0, f}, b};
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : mon
    logic [15:0] e16;
    logic [7:0]  e8;
    logic [3:0]  e4;
    logic [3:0]  strb;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        in_alu = 1'b0;
      end else begin
        if (RF_RdData_VLD) rdvld_cyc = cyc_n;
        strb = {RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD};
        if (|strb) chk("strobe_exclusive", 32'($countones(strb)), 1);
        if (RF_WrEn) begin
          if (wr_q.size() == 0) chk("wr_unexpected", 32'(RF_WrEn), 0);
          else begin
            e16 = wr_q.pop_front();
            chk("wr_addr_data", {16'h0, 8'(RF_Address), RF_WrData}, {16'h0, e16});
          end
        end
        if (RF_RdEn) begin
          if (rd_q.size() == 0) chk("rd_unexpected", 32'(RF_RdEn), 0);
          else begin
            e8 = rd_q.pop_front();
            chk("rd_addr", 32'(RF_Address), 32'(e8));
          end
        end
        if (ALU_EN) begin
          in_alu = 1'b1;
          if (alu_q.size() == 0) chk("alu_unexpected", 32'(ALU_EN), 0);
          else begin
            e4 = alu_q.pop_front();
            chk("alu_fun", 32'(ALU_FUN), 32'(e4));
          end
        end
        if (TX_D_VLD) begin
          tx_cyc = cyc_n;
          if (tx_q.size() == 0) chk("tx_unexpected", 32'(TX_D_VLD), 0);
          else begin
            e8 = tx_q.pop_front();
            chk("tx_data", 32'(TX_P_DATA), 32'(e8));
          end
        end
        if (CMD_ERR) begin
          chk("cmd_err_expected", 32'(err_pend > 0), 1);
          if (err_pend > 0) err_pend--;
        end
        if (CLK_GATE_EN || in_alu) chk("clk_gate", 32'(CLK_GATE_EN), 32'(in_alu));
        if (ALU_OUT_VLD && in_alu) in_alu = 1'b0;
      end
    end
  end

  // ---------------- RF / ALU / TX FIFO environment ----------------
  initial begin : resp
    logic [7:0]  a;
    logic [15:0] r;
    for (int i = 0; i < 256; i++) rf[i] = 8'h00;
    forever begin
      @(negedge CLK);
      if (RST && RF_WrEn) rf[8'(RF_Address)] = RF_WrData;
      if (RST && (RF_RdEn || ALU_EN)) begin
        a = 8'(RF_Address);
        r = alu_ref(rf[0], rf[1], ALU_FUN);
        if (RF_RdEn) begin
          repeat ($urandom_range(1, 4)) @(posedge CLK);
          #1 RF_RdData = rf[a]; RF_RdData_VLD = 1'b1;
          @(posedge CLK);
          #1 RF_RdData_VLD = 1'b0;
        end else begin
          repeat ($urandom_range(1, 4)) @(posedge CLK);
          #1 ALU_OUT = r; ALU_OUT_VLD = 1'b1;
          @(posedge CLK);
          #1 ALU_OUT_VLD = 1'b0;
        end
        if (stall_n > 0) begin
          TX_FULL = 1'b1;
          repeat (stall_n) @(posedge CLK);
          #1 TX_FULL = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic e);
    RX_P_DATA = b; RX_D_VLD = 1'b1; RX_ERR = e;
    cyc();
    RX_D_VLD = 1'b0; RX_ERR = 1'b0; RX_P_DATA = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (noise) begin
      repeat ($urandom_range(0, 1)) cyc();
      if ($urandom_range(0, 3) == 0) send_raw(8'($urandom), 1'b1);
    end
    send_raw(b, 1'b0);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a & AMASK, d});
    ref_mem[a & AMASK] = d;
    send_byte(8'hAA); send_byte(a); send_byte(d);
  endtask

  task automatic cmd_read(input logic [7:0] a);
    rd_q.push_back(a & AMASK);
    tx_q.push_back(ref_mem[a & AMASK]);
    send_byte(8'hBB); send_byte(a);
  endtask

  task automatic cmd_ops(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f);
    logic [15:0] r;
    wr_q.push_back({8'h00, x});
    wr_q.push_back({8'h01, y});
    ref_mem[0] = x; ref_mem[1] = y;
    alu_q.push_back(f[3:0]);
    r = alu_ref(x, y, f[3:0]);
    tx_q.push_back(r[7:0]); tx_q.push_back(r[15:8]);
    send_byte(8'hCC); send_byte(x); send_byte(y); send_byte(f);
  endtask

  task automatic cmd_alu(input logic [7:0] f);
    logic [15:0] r;
    alu_q.push_back(f[3:0]);
    r = alu_ref(ref_mem[0], ref_mem[1], f[3:0]);
    tx_q.push_back(r[7:0]); tx_q.push_back(r[15:8]);
    send_byte(8'hDD); send_byte(f);
  endtask

  task automatic cmd_bad(input logic [7:0] b);
    err_pend++;
    send_byte(b);
  endtask

  task automatic drain();
    int n = 0;
    int pend;
    pend = wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() + err_pend;
    while (pend != 0 && n < 3000) begin
      cyc(); n++;
      pend = wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size() + err_pend;
    end
    chk("drain_pending", 32'(pend), 0);
    if (pend != 0) begin
      wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); err_pend = 0;
    end
    repeat (2) cyc();
  endtask

  function automatic logic [31:0] outs();
    return 32'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
                TX_P_DATA, TX_D_VLD, CMD_ERR});
  endfunction

  initial begin : stim
    int l0, l1;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // reset with a valid byte present: must be ignored
    RST = 1'b0; RX_P_DATA = 8'h55; RX_D_VLD = 1'b1;
    repeat (3) cyc();
    RST = 1'b1; RX_D_VLD = 1'b0;
    chk("reset_outputs", outs(), 0);
    repeat (2) cyc();

    // basic write, then outputs hold their values
    cmd_write(8'h05, 8'h3C); drain();
    repeat (3) cyc();
    chk("hold_addr_data", 32'({RF_Address, RF_WrData}), 32'({4'h5, 8'h3C}));

    // read path and TX_FULL back-pressure
    stall_n = 0;
    cmd_write(8'h02, 8'h7E); drain();
    cmd_read(8'h02); drain();
    l0 = tx_cyc - rdvld_cyc;
    stall_n = 10;
    cmd_read(8'h02); drain();
    l1 = tx_cyc - rdvld_cyc;
    chk("txfull_delay", 32'(l1 - l0), 10);
    stall_n = 0;

    // operand + ALU command
    cmd_ops(8'h10, 8'h20, 8'h00); drain();

    // bad command, plain timeout
    cmd_bad(8'h55); drain();
    err_pend++;
    send_raw(8'hAA, 1'b0);
    repeat (TO_CYC + 4) cyc();
    drain();

    // bytes arriving exactly at expiry win
    wr_q.push_back({8'h05, 8'hC3});
    ref_mem[5] = 8'hC3;
    send_raw(8'hAA, 1'b0); repeat (TO_CYC - 1) cyc();
    send_raw(8'h05, 1'b0); repeat (TO_CYC - 1) cyc();
    send_raw(8'hC3, 1'b0);
    drain();

    // one cycle later the timeout fires and the byte is decoded as a command
    err_pend += 2;
    send_raw(8'hAA, 1'b0); repeat (TO_CYC) cyc();
    send_raw(8'h99, 1'b0);
    drain();

    // errored bytes do not restart the timeout
    err_pend++;
    send_raw(8'hAA, 1'b0);
    for (int i = 0; i < TO_CYC; i++) begin
      if (i % 3 == 0) send_raw(8'h05, 1'b1);
      else cyc();
    end
    drain();

    // errored byte between address and data is skipped
    wr_q.push_back({8'h05, 8'h11});
    ref_mem[5] = 8'h11;
    send_raw(8'hAA, 1'b0); send_raw(8'h05, 1'b0);
    send_raw(8'h77, 1'b1); send_raw(8'h11, 1'b0);
    drain();

    // reset mid-command abandons it
    send_raw(8'hAA, 1'b0); send_raw(8'h05, 1'b0);
    RST = 1'b0; RX_P_DATA = 8'h22; RX_D_VLD = 1'b1;
    cyc();
    RST = 1'b1; RX_D_VLD = 1'b0;
    chk("reset_mid_cmd_outputs", outs(), 0);
    err_pend++;
    send_raw(8'h11, 1'b0);
    drain();

    // randomized traffic
    noise = 1'b1;
    for (int it = 0; it < 120; it++) begin
      stall_n = $urandom_range(0, 3);
      case ($urandom_range(0, 6))
        0: cmd_write(8'($urandom), 8'($urandom));
        1: cmd_read(8'($urandom));
        2: cmd_ops(8'($urandom), 8'($urandom), 8'($urandom));
        3: cmd_alu(8'($urandom));
        4: begin
          b = 8'($urandom);
          while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b = 8'($urandom);
          cmd_bad(b);
        end
        5: begin
          cmd_read(8'($urandom));
          err_pend++;
          send_raw(8'hAA, 1'b0);
        end
        default: begin
          cmd_alu(8'($urandom));
          err_pend++;
          send_raw(8'($urandom), 1'b0);
        end
      endcase
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
